// File: rtl/mem_access_ctrl_pkg.sv
// Shared decode constants, FSM state encoding and fault causes for the
// data-memory access controller.
package mem_access_ctrl_pkg;

  localparam logic [6:0] OpcLoad  = 7'b0000011;
  localparam logic [6:0] OpcStore = 7'b0100011;

  localparam logic [2:0] F3Byte  = 3'b000;
  localparam logic [2:0] F3Half  = 3'b001;
  localparam logic [2:0] F3Word  = 3'b010;
  localparam logic [2:0] F3ByteU = 3'b100;
  localparam logic [2:0] F3HalfU = 3'b101;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StIssue = 3'd1;
  localparam logic [2:0] StWait  = 3'd2;
  localparam logic [2:0] StDone  = 3'd3;
  localparam logic [2:0] StFault = 3'd4;

  localparam logic [1:0] CauseNone     = 2'b00;
  localparam logic [1:0] CauseMisalign = 2'b01;
  localparam logic [1:0] CauseTimeout  = 2'b10;
  localparam logic [1:0] CauseIllegal  = 2'b11;

  function automatic logic funct_illegal(input logic is_store, input logic [2:0] funct);
    logic bad;
    case (funct)
      F3Byte, F3Half, F3Word: bad = 1'b0;
      F3ByteU, F3HalfU:       bad = is_store;
      default:                bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Access size comes from funct[1:0]; byte accesses can never be misaligned.
  function automatic logic access_misaligned(input logic [2:0] funct, input logic [1:0] off);
    logic mis;
    case (funct[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_fmt.sv
// Combinational lane formatting: store byte enables and replication, load
// shift and extension, plus illegal/misaligned classification.
module mem_lane_fmt
  import mem_access_ctrl_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        is_load,
  output logic        is_store,
  output logic        illegal,
  output logic        misaligned,
  output logic [3:0]  we,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data
);

  logic [15:0] sh;

  assign is_load    = (opcode == OpcLoad);
  assign is_store   = (opcode == OpcStore);
  assign illegal    = funct_illegal(is_store, funct);
  assign misaligned = access_misaligned(funct, off);
  assign sh         = 16'(rdata >> {off, 3'b000});

  always_comb begin
    we        = 4'b0000;
    wdata_rep = 32'h0;
    if (is_store) begin
      case (funct)
        F3Byte: begin
          we        = 4'b0001 << off;
          wdata_rep = {4{wdata[7:0]}};
        end
        F3Half: begin
          we        = 4'b0011 << off;
          wdata_rep = {2{wdata[15:0]}};
        end
        F3Word: begin
          we        = 4'b1111;
          wdata_rep = wdata;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    load_data = 32'h0;
    case (funct)
      F3Byte:  load_data = {{24{sh[7]}}, sh[7:0]};
      F3ByteU: load_data = {24'h0, sh[7:0]};
      F3Half:  load_data = {{16{sh[15]}}, sh[15:0]};
      F3HalfU: load_data = {16'h0, sh[15:0]};
      F3Word:  load_data = rdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences one load or store at a time between the memory pipeline stage and
// a variable-latency data memory, with fault reporting and timeout.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_opcode,
  input  logic [2:0]  req_funct,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        stall,
  output logic        resp_valid,
  output logic        resp_is_load,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_WIDTH-1:0] TimeoutLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [2:0]           state_q, state_d;
  logic [6:0]           opcode_q;
  logic [2:0]           funct_q;
  logic [31:0]          addr_q, wdata_q;
  logic [4:0]           rd_q;
  logic [1:0]           cause_q, cause_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic        in_idle, accept, timeout_hit;
  logic [6:0]  fmt_opcode;
  logic [2:0]  fmt_funct;
  logic [1:0]  fmt_off;
  logic        fmt_is_load, fmt_is_store, fmt_illegal, fmt_misaligned;
  logic [3:0]  fmt_we;
  logic [31:0] fmt_wdata, fmt_load_data;

  assign in_idle = (state_q == StIdle);

  // In IDLE the formatter classifies the incoming request; afterwards it works
  // on the latched fields.
  assign fmt_opcode = in_idle ? req_opcode    : opcode_q;
  assign fmt_funct  = in_idle ? req_funct     : funct_q;
  assign fmt_off    = in_idle ? req_addr[1:0] : addr_q[1:0];

  mem_lane_fmt u_lane_fmt (
    .opcode     (fmt_opcode),
    .funct      (fmt_funct),
    .off        (fmt_off),
    .wdata      (wdata_q),
    .rdata      (mem_rdata),
    .is_load    (fmt_is_load),
    .is_store   (fmt_is_store),
    .illegal    (fmt_illegal),
    .misaligned (fmt_misaligned),
    .we         (fmt_we),
    .wdata_rep  (fmt_wdata),
    .load_data  (fmt_load_data)
  );

  assign accept      = in_idle && req_valid && (fmt_is_load || fmt_is_store);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TimeoutLast);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (fmt_illegal) begin
            state_d = StFault;
            cause_d = CauseIllegal;
          end else if (fmt_misaligned) begin
            state_d = StFault;
            cause_d = CauseMisalign;
          end else begin
            state_d = StIssue;
            cause_d = CauseNone;
            cnt_d   = '0;
          end
        end
      end
      StIssue: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (mem_req_ready) begin
          state_d = fmt_is_load ? StWait : StDone;
        end else if (timeout_hit) begin
          state_d = StFault;
          cause_d = CauseTimeout;
        end
      end
      StWait: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (mem_resp_valid) begin
          state_d = StDone;
          rdata_d = fmt_load_data;
        end else if (timeout_hit) begin
          state_d = StFault;
          cause_d = CauseTimeout;
        end
      end
      StDone, StFault: state_d = StIdle;
      default:         state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      opcode_q <= '0;
      funct_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      cause_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        opcode_q <= req_opcode;
        funct_q  <= req_funct;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        rd_q     <= req_rd;
      end
    end
  end

  assign req_ready     = in_idle;
  assign stall         = !in_idle;
  assign mem_req_valid = (state_q == StIssue);
  assign mem_addr      = mem_req_valid ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_we        = mem_req_valid ? fmt_we : 4'b0000;
  assign mem_wdata     = mem_req_valid ? fmt_wdata : 32'h0;
  assign resp_valid    = (state_q == StDone);
  assign resp_is_load  = resp_valid && fmt_is_load;
  assign resp_rdata    = resp_is_load ? rdata_q : 32'h0;
  assign resp_rd       = rd_q;
  assign fault         = (state_q == StFault);
  assign fault_cause   = fault ? cause_q : CauseNone;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed table, hand-written
// corner sequences and randomized transactions against a reference model.
module tb_mem_access_ctrl;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, t_req_valid;
  logic [6:0]  req_opcode;
  logic [2:0]  req_funct;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req_ready, mem_resp_valid;
  logic [31:0] mem_rdata;

  logic        req_ready, stall, resp_valid, resp_is_load, fault, mem_req_valid;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [4:0]  resp_rd;
  logic [1:0]  fault_cause;
  logic [3:0]  mem_we;

  logic        t_req_ready, t_stall, t_resp_valid, t_resp_is_load, t_fault, t_mem_req_valid;
  logic [31:0] t_resp_rdata, t_mem_addr, t_mem_wdata;
  logic [4:0]  t_resp_rd;
  logic [1:0]  t_fault_cause;
  logic [3:0]  t_mem_we;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_funct(req_funct), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .stall(stall), .resp_valid(resp_valid),
    .resp_is_load(resp_is_load), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
    .fault(fault), .fault_cause(fault_cause), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  // Short-timeout instance whose memory never accepts.
  mem_access_ctrl #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(3)) dut_to (
    .clk(clk), .rst(rst), .req_valid(t_req_valid), .req_ready(t_req_ready),
    .req_opcode(req_opcode), .req_funct(req_funct), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .stall(t_stall), .resp_valid(t_resp_valid),
    .resp_is_load(t_resp_is_load), .resp_rdata(t_resp_rdata), .resp_rd(t_resp_rd),
    .fault(t_fault), .fault_cause(t_fault_cause), .mem_req_valid(t_mem_req_valid),
    .mem_req_ready(1'b0), .mem_addr(t_mem_addr), .mem_we(t_mem_we),
    .mem_wdata(t_mem_wdata), .mem_resp_valid(1'b0), .mem_rdata(32'h0)
  );

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdat;
    int          rsp_dly;
    logic [1:0]  cause;
    logic [3:0]  we;
    logic [31:0] ewd;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model from the access rules: size, alignment, lanes, extension.
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rdat,
                       output logic [1:0] cause, output logic [3:0] we,
                       output logic [31:0] ewd, output logic [31:0] erd);
    int sz, off;
    bit legal;
    logic [31:0] v, mask;
    off   = int'(addr % 4);
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    sz    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (!legal) cause = 2'b11;
    else if ((addr % sz) != 0) cause = 2'b01;
    else cause = 2'b00;
    we  = st ? 4'(((1 << sz) - 1) << off) : 4'b0000;
    ewd = (sz == 1) ? wd[7:0] * 32'h01010101 : (sz == 2) ? wd[15:0] * 32'h00010001 : wd;
    mask = (sz == 4) ? 32'hFFFFFFFF : 32'((1 << (8 * sz)) - 1);
    v = (rdat >> (8 * off)) & mask;
    if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
    erd = st ? 32'h0 : v;
  endtask

  task automatic run_txn(input string nm, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                         input int rdy_dly, input int rsp_dly, input logic junk,
                         input logic [1:0] e_cause, input logic [3:0] e_we,
                         input logic [31:0] e_wd, input logic [31:0] e_rd);
    logic [4:0] rd;
    rd = 5'($urandom);
    chk({nm, ":req_ready"}, req_ready, 1);
    req_valid  = 1'b1;
    req_opcode = st ? OPC_STORE : OPC_LOAD;
    req_funct  = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_rd     = rd;
    step();
    req_valid = 1'b0;
    req_addr  = 32'($urandom);
    if (e_cause != 2'b00) begin
      chk({nm, ":fault"}, fault, 1);
      chk({nm, ":fault_cause"}, fault_cause, e_cause);
      chk({nm, ":no_mem_req"}, mem_req_valid, 0);
      step();
      chk({nm, ":fault_clear"}, fault, 0);
      chk({nm, ":idle_after_fault"}, req_ready, 1);
    end else begin
      for (int i = 0; i <= rdy_dly; i++) begin
        chk({nm, ":mem_req_valid"}, mem_req_valid, 1);
        chk({nm, ":stall_issue"}, stall, 1);
        chk({nm, ":no_resp_issue"}, resp_valid, 0);
        chk({nm, ":mem_addr"}, mem_addr, {addr[31:2], 2'b00});
        chk({nm, ":mem_we"}, mem_we, e_we);
        if (st) chk({nm, ":mem_wdata"}, mem_wdata, e_wd);
        if (i == rdy_dly) begin
          mem_req_ready = 1'b1;
          if (!st && junk) begin
            mem_resp_valid = 1'b1;
            mem_rdata      = ~rdat;
          end
        end
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
      end
      if (!st) begin
        for (int i = 0; i <= rsp_dly; i++) begin
          chk({nm, ":no_resp_wait"}, resp_valid, 0);
          chk({nm, ":stall_wait"}, stall, 1);
          chk({nm, ":mem_req_dropped"}, mem_req_valid, 0);
          if (i == rsp_dly) begin
            mem_resp_valid = 1'b1;
            mem_rdata      = rdat;
          end
          step();
          mem_resp_valid = 1'b0;
          mem_rdata      = 32'h0;
        end
      end
      chk({nm, ":resp_valid"}, resp_valid, 1);
      chk({nm, ":resp_is_load"}, resp_is_load, !st);
      chk({nm, ":resp_rdata"}, resp_rdata, e_rd);
      if (!st) chk({nm, ":resp_rd"}, resp_rd, rd);
      step();
      chk({nm, ":resp_pulse"}, resp_valid, 0);
      chk({nm, ":back_to_idle"}, req_ready, 1);
    end
  endtask

  initial begin
    logic [1:0]  m_cause;
    logic [3:0]  m_we;
    logic [31:0] m_wd, m_rd, r_addr, r_wd, r_rdat;
    logic [2:0]  r_f3;
    logic        r_st;

    //          st  f3  addr          wd            rdat          rsp cause  we       ewd           erd
    tbl[0]  = '{1, 3'd0, 32'h1003, 32'h000000AB, 32'h0,        0, 2'b00, 4'b1000, 32'hABABABAB, 32'h0};
    tbl[1]  = '{0, 3'd0, 32'h2002, 32'h0,        32'h0080FF00, 5, 2'b00, 4'b0000, 32'h0, 32'hFFFFFF80};
    tbl[2]  = '{0, 3'd4, 32'h2002, 32'h0,        32'h0080FF00, 5, 2'b00, 4'b0000, 32'h0, 32'h00000080};
    tbl[3]  = '{0, 3'd1, 32'h2001, 32'h0,        32'h0,        0, 2'b01, 4'b0000, 32'h0, 32'h0};
    tbl[4]  = '{0, 3'd3, 32'h2000, 32'h0,        32'h0,        0, 2'b11, 4'b0000, 32'h0, 32'h0};
    tbl[5]  = '{0, 3'd6, 32'h2003, 32'h0,        32'h0,        0, 2'b11, 4'b0000, 32'h0, 32'h0};
    tbl[6]  = '{1, 3'd1, 32'h1002, 32'h1234BEEF, 32'h0,        0, 2'b00, 4'b1100, 32'hBEEFBEEF, 32'h0};
    tbl[7]  = '{1, 3'd2, 32'h1000, 32'hDEADBEEF, 32'h0,        0, 2'b00, 4'b1111, 32'hDEADBEEF, 32'h0};
    tbl[8]  = '{0, 3'd1, 32'h2002, 32'h0,        32'h80010000, 1, 2'b00, 4'b0000, 32'h0, 32'hFFFF8001};
    tbl[9]  = '{0, 3'd5, 32'h2002, 32'h0,        32'h80010000, 0, 2'b00, 4'b0000, 32'h0, 32'h00008001};
    tbl[10] = '{0, 3'd2, 32'h2004, 32'h0,        32'h12345678, 2, 2'b00, 4'b0000, 32'h0, 32'h12345678};
    tbl[11] = '{1, 3'd2, 32'h1002, 32'h11111111, 32'h0,        0, 2'b01, 4'b0000, 32'h0, 32'h0};
    tbl[12] = '{1, 3'd5, 32'h1001, 32'h11111111, 32'h0,        0, 2'b11, 4'b0000, 32'h0, 32'h0};
    tbl[13] = '{1, 3'd0, 32'h1001, 32'h0000005A, 32'h0,        0, 2'b00, 4'b0010, 32'h5A5A5A5A, 32'h0};

    rst = 1'b1;
    req_valid = 1'b0; t_req_valid = 1'b0;
    req_opcode = '0; req_funct = '0; req_addr = '0; req_wdata = '0; req_rd = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    #3;
    chk("rst:req_ready", req_ready, 1);
    chk("rst:stall", stall, 0);
    chk("rst:resp_valid", resp_valid, 0);
    chk("rst:fault", fault, 0);
    chk("rst:mem_req_valid", mem_req_valid, 0);
    chk("rst:mem_we", mem_we, 0);
    chk("rst:resp_rd", resp_rd, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 14; i++)
      run_txn($sformatf("tbl%0d", i), tbl[i].st, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].rdat,
              0, tbl[i].rsp_dly, 1'b1, tbl[i].cause, tbl[i].we, tbl[i].ewd, tbl[i].erd);

    // Non-memory opcode is consumed silently.
    req_valid = 1'b1; req_opcode = 7'b0110011; req_funct = 3'd0; req_addr = 32'h0;
    step();
    req_valid = 1'b0;
    chk("alu:stall", stall, 0);
    chk("alu:mem_req_valid", mem_req_valid, 0);
    chk("alu:req_ready", req_ready, 1);
    step();
    chk("alu:resp_valid", resp_valid, 0);
    chk("alu:fault", fault, 0);

    // Timeout: fault 4 cycles after entering ISSUE with memory never ready.
    t_req_valid = 1'b1; req_opcode = OPC_LOAD; req_funct = 3'd2; req_addr = 32'h3000;
    step();
    t_req_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("to:no_fault_c%0d", i), t_fault, 0);
      chk($sformatf("to:mem_req_c%0d", i), t_mem_req_valid, 1);
    end
    step();
    chk("to:fault", t_fault, 1);
    chk("to:cause", t_fault_cause, 2'b10);
    chk("to:mem_req_dropped", t_mem_req_valid, 0);
    step();
    chk("to:req_ready", t_req_ready, 1);
    chk("to:fault_clear", t_fault, 0);

    // Reset while in WAIT, then a stale response.
    req_valid = 1'b1; req_opcode = OPC_LOAD; req_funct = 3'd2; req_addr = 32'h4000;
    step();
    req_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    step();
    chk("rstwait:in_wait", stall, 1);
    rst = 1'b1;
    #1;
    chk("rstwait:stall", stall, 0);
    chk("rstwait:req_ready", req_ready, 1);
    chk("rstwait:mem_req_valid", mem_req_valid, 0);
    step();
    rst = 1'b0;
    mem_resp_valid = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_resp_valid = 1'b0; mem_rdata = 32'h0;
    chk("rstwait:no_resp", resp_valid, 0);
    chk("rstwait:idle", stall, 0);
    run_txn("post_rst_lw", 1'b0, 3'd2, 32'h4008, 32'h0, 32'h0BADBEEF, 1, 1, 1'b0,
            2'b00, 4'b0000, 32'h0, 32'h0BADBEEF);

    // Randomized transactions against the reference model.
    for (int n = 0; n < 60; n++) begin
      r_st   = 1'($urandom);
      r_f3   = 3'($urandom);
      r_addr = 32'($urandom);
      r_wd   = 32'($urandom);
      r_rdat = 32'($urandom);
      model(r_st, r_f3, r_addr, r_wd, r_rdat, m_cause, m_we, m_wd, m_rd);
      run_txn($sformatf("rnd%0d", n), r_st, r_f3, r_addr, r_wd, r_rdat,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1'($urandom),
              m_cause, m_we, m_wd, m_rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequences one data-memory load or store at a time between the pipeline's memory stage and a variable-latency data memory with a valid/ready request channel and a valid-only response channel.
- Stores: generates byte enables and lane-replicated write data.
- Loads: lane-shifts and sign/zero-extends returned data to a 32-bit value.
- Flags misaligned accesses, illegal funct codes and memory timeouts.
- Holds `stall` high while an access is in flight.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in ISSUE or WAIT before a timeout fault. 0 disables the timeout.
- CNT_WIDTH, 8: width of the timeout counter. Must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  pipeline presents a request
- req_ready  out  1  controller accepts a request (high only in IDLE)
- req_opcode  in  7  instruction opcode
- req_funct  in  3  funct3
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bits significant)
- req_rd  in  5  load destination register
- stall  out  1  high whenever state != IDLE
- resp_valid  out  1  one-cycle completion pulse
- resp_is_load  out  1  qualifies resp_valid: 1 = load, 0 = store
- resp_rdata  out  32  formatted load data; 0 for stores
- resp_rd  out  5  latched rd
- fault  out  1  one-cycle fault pulse
- fault_cause  out  2  01 misaligned, 10 timeout, 11 illegal funct; valid with fault
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  32  {req_addr[31:2], 2'b00}
- mem_we  out  4  byte write enables; 0 for loads
- mem_wdata  out  32  lane-replicated store data
- mem_resp_valid  in  1  load data valid
- mem_rdata  in  32  raw word from memory

Behaviour:
Reset:
- Async reset forces IDLE immediately.
- All outputs 0 except req_ready = 1.
- Latched fields and timeout counter cleared.
- Reset mid-access drops mem_req_valid in the same cycle. Any later mem_resp_valid is ignored.

Decode constants:
- Opcodes: LOAD = 7'b0000011, STORE = 7'b0100011.
- Load funct: LB 000, LH 001, LW 010, LBU 100, LHU 101. Others are illegal.
- Store funct: SB 000, SH 001, SW 010. Others are illegal.

Misalignment:
- Halfword accesses with addr[0] = 1.
- Word accesses with addr[1:0] != 0.
- Illegal funct takes priority over misaligned.

FSM states: IDLE, ISSUE, WAIT, DONE, FAULT.
- IDLE
  - req_valid with a non-memory opcode: consumed, no response, stay IDLE.
  - req_valid with a memory opcode: latch opcode, funct, addr, wdata, rd.
    - Illegal or misaligned: go to FAULT.
    - Otherwise: go to ISSUE and clear the counter.
- ISSUE
  - mem_req_valid = 1; mem_addr, mem_we and mem_wdata are driven from latched registers and stay stable.
  - On mem_req_ready: store goes to DONE, load goes to WAIT.
  - mem_resp_valid arriving in the same cycle as a load's mem_req_ready is ignored. The response must arrive in a later cycle.
- WAIT
  - On mem_resp_valid: register the formatted data, go to DONE.
- DONE
  - resp_valid = 1 for exactly one cycle, resp_is_load set, resp_rd driven. Then go to IDLE.
- FAULT
  - fault = 1 and fault_cause driven for one cycle. No memory request is issued. Then go to IDLE.

Timeout:
- The counter increments each cycle in ISSUE or WAIT.
- When the counter equals TIMEOUT_CYCLES - 1 and the exit condition is not met, go to FAULT with cause 10 and drop mem_req_valid.
- Simultaneous exit condition and timeout: the exit condition wins.

Store formatting, with off = addr[1:0]:
- SB: mem_we = 4'b0001 << off; mem_wdata = {4{wdata[7:0]}}.
- SH: mem_we = 4'b0011 << off; mem_wdata = {2{wdata[15:0]}}.
- SW: mem_we = 4'b1111; mem_wdata = wdata.

Load formatting:
- sh = mem_rdata >> (8*off).
- LB: sign-extend sh[7:0]. LBU: zero-extend sh[7:0].
- LH: sign-extend sh[15:0]. LHU: zero-extend sh[15:0].
- LW: mem_rdata unchanged.

Latency:
- Store: accept, then ISSUE, then DONE. Minimum 3 cycles from acceptance to resp_valid when mem_req_ready is high.
- Load: minimum 4 cycles.
- Back-to-back: a new request is accepted in the cycle after DONE.

Decomposition:
- Shared package (extends the existing opcode/funct constant headers): opcode and funct constants, FSM state encoding, fault_cause encodings.
- One natural sub-module: mem_lane_fmt, purely combinational. Covers store byte-enable and replication, load shift and extension, and misaligned/illegal detection. The controller instantiates it on the latched fields.

Test Plan:
1. SB, addr 0x1003, wdata 0xAB, mem_req_ready tied 1 -> mem_we = 4'b1000, mem_wdata = 0xABABABAB, mem_addr = 0x1000; resp_valid 3 cycles after acceptance with resp_is_load = 0.
2. LB, addr 0x2002, mem_rdata 0x0080FF00 after 5 wait cycles -> resp_rdata = 0xFFFFFF80, resp_rd = latched rd; stall high throughout. LBU on the same data -> 0x00000080.
3. LH, addr 0x2001 -> fault with cause 01, mem_req_valid never asserted. Load with funct 3'b011 -> fault with cause 11.
4. TIMEOUT_CYCLES = 4, mem_req_ready held 0 -> fault with cause 10 exactly 4 cycles after entering ISSUE, then back to IDLE with req_ready = 1.
5. rst asserted while in WAIT, then mem_resp_valid pulsed after reset -> outputs at reset values, no resp_valid, next LW completes normally.
6. Opcode 7'b0110011 with req_valid -> no mem_req_valid, no resp_valid, stall stays 0.
